// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : FSM encoding (IDLE, RUN, DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin (one bit), bout = borrow.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow-in
//   d    : difference bit
//   bout : borrow-out
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow comes in.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, diff = a - b - bin, LSB first, one bit per clock.
// Ports:
//   clock  : system clock, rising edge active
//   resetn : asynchronous active-low reset
//   start  : request pulse, sampled only in IDLE
//   a, b   : minuend / subtrahend, sampled on the accepting edge
//   bin    : borrow-in, sampled on the accepting edge
//   busy   : high while an operation is running
//   done   : one-cycle pulse when diff/bout are updated
//   diff   : registered result, held until the next completion
//   bout   : registered borrow-out (1 = a < b + bin, unsigned)
module serial_subtractor
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIDTH-1:0]   a_sr_r;
  logic [WIDTH-1:0]   b_sr_r;
  // Only WIDTH-1 bits are stored; the final bit goes straight into diff.
  logic [WIDTH-2:0]   res_sr_r;
  logic [WIDTH-1:0]   res_shift_s;
  logic               brw_r;
  logic [CW-1:0]      cnt_r;
  logic               d_s;
  logic               brw_nxt_s;
  logic               last_s;

  full_subtractor u_cell (
    .a    (a_sr_r[0]),
    .b    (b_sr_r[0]),
    .bin  (brw_r),
    .d    (d_s),
    .bout (brw_nxt_s)
  );

  assign last_s      = (cnt_r == LAST_CNT);
  assign res_shift_s = {d_s, res_sr_r};

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Registered status flags, derived from the state being entered.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s == RUN);
      done <= (state_nxt_s == DONE);
    end
  end

  // Operand shifters, borrow flop, bit counter and result capture.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      a_sr_r   <= {WIDTH{1'b0}};
      b_sr_r   <= {WIDTH{1'b0}};
      res_sr_r <= {(WIDTH-1){1'b0}};
      brw_r    <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sr_r   <= a;
            b_sr_r   <= b;
            brw_r    <= bin;
            cnt_r    <= {CW{1'b0}};
            res_sr_r <= {(WIDTH-1){1'b0}};
          end
        end
        RUN: begin
          a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
          brw_r    <= brw_nxt_s;
          res_sr_r <= res_shift_s[WIDTH-1:1];
          cnt_r    <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            diff <= res_shift_s;
            bout <= brw_nxt_s;
          end
        end
        default: begin
          brw_r <= brw_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int total = 0;
  int bad   = 0;

  // Last completed result as the outside world should see it.
  logic [W-1:0] hold_diff;
  logic         hold_bout;

  serial_subtractor #(.WIDTH(W)) dut (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .a      (a),
    .b      (b),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .bout   (bout)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int d;
    logic [W-1:0] r;
    d = int'(x) - int'(y) - int'(c);
    r = d[W-1:0];
    return {(int'(x) < int'(y) + int'(c)), r};
  endfunction

  // One full operation starting from IDLE at a negedge; optional stray start in RUN cycle 2.
  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                    input bit inject, input string tag);
    logic [W:0] exp;
    exp   = ref_sub(x, y, c);
    a     = x;
    b     = y;
    bin   = c;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    bin   = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      chk({tag, ".busy"}, 32'(busy), 32'd1);
      chk({tag, ".nodone"}, 32'(done), 32'd0);
      chk({tag, ".hold"}, 32'({hold_bout, diff}), 32'({hold_bout, hold_diff}));
      if (inject && i == 1) begin
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
    end
    start = 1'b0;
    chk({tag, ".done"}, 32'(done), 32'd1);
    chk({tag, ".busy_off"}, 32'(busy), 32'd0);
    chk({tag, ".diff"}, 32'(diff), 32'(exp[W-1:0]));
    chk({tag, ".bout"}, 32'(bout), 32'(exp[W]));
    hold_diff = exp[W-1:0];
    hold_bout = exp[W];
    @(negedge clock);
    chk({tag, ".pulse1"}, 32'(done), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [W:0]   exp;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;

    resetn    = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;
    hold_diff = '0;
    hold_bout = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.diff", 32'(diff), 32'd0);
    chk("rst.bout", 32'(bout), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Directed cases.
    op(4'd7, 4'd3, 1'b0, 1'b0, "d7m3");
    op(4'd3, 4'd7, 1'b0, 1'b0, "d3m7");
    op(4'd5, 4'd5, 1'b1, 1'b0, "d5m5b");
    op(4'd0, 4'd0, 1'b0, 1'b0, "d0m0");
    op(4'd9, 4'd2, 1'b0, 1'b1, "stray");
    op(4'd0, 4'd15, 1'b1, 1'b0, "min");
    op(4'd15, 4'd0, 1'b0, 1'b0, "max");

    // Asynchronous reset in the middle of a run.
    a     = 4'd8;
    b     = 4'd1;
    bin   = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    chk("mid.busy_pre", 32'(busy), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("mid.busy", 32'(busy), 32'd0);
    chk("mid.done", 32'(done), 32'd0);
    chk("mid.diff", 32'(diff), 32'd0);
    chk("mid.bout", 32'(bout), 32'd0);
    hold_diff = '0;
    hold_bout = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);
    chk("mid.after", 32'(busy), 32'd0);
    op(4'd15, 4'd15, 1'b0, 1'b0, "fresh");

    // Randomized operations.
    for (int n = 0; n < 20; n++) begin
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "rnd");
    end

    // Back-to-back with start held high; operands churn every cycle.
    start = 1'b1;
    for (int n = 0; n < 6; n++) begin
      ra  = W'($urandom);
      rb  = W'($urandom);
      rc  = 1'($urandom);
      a   = ra;
      b   = rb;
      bin = rc;
      exp = ref_sub(ra, rb, rc);
      for (int i = 0; i < W; i++) begin
        @(negedge clock);
        a   = W'($urandom);
        b   = W'($urandom);
        bin = 1'($urandom);
        chk("b2b.busy", 32'(busy), 32'd1);
        chk("b2b.hold", 32'(diff), 32'(hold_diff));
      end
      @(negedge clock);
      a   = W'($urandom);
      b   = W'($urandom);
      bin = 1'($urandom);
      chk("b2b.done", 32'(done), 32'd1);
      chk("b2b.res", 32'({bout, diff}), 32'(exp));
      hold_diff = exp[W-1:0];
      hold_bout = exp[W];
      @(negedge clock);
      chk("b2b.gap", 32'({busy, done}), 32'd0);
    end
    start = 1'b0;
    @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
